rr_arbiter_4: RTL and testbench
===============================

Name: rr_arbiter_4

Overview:
- Round-robin arbiter that shares one 4-way resource between four requesters.
- Issues a registered one-hot grant plus its 2-bit encoded index; one-hot equals the 2-to-4 decode of the index.
- Enforces a maximum hold time so one requester cannot starve the others.
- Sits in front of the 2-to-4 decoder path: the decoder's select input is driven from gnt_id.

Parameters:
MAX_HOLD, 8, max consecutive grant cycles per ownership while others wait; legal range 1..255; hold counter is 8 bits.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
en  input  1  arbitration enable; 0 = release and block grants
req  input  4  request vector, bit i = requester i
gnt  output  4  one-hot grant, registered
gnt_id  output  2  index of granted requester, registered
gnt_valid  output  1  1 when gnt is non-zero

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: gnt=0000, gnt_id=00, gnt_valid=0, state=IDLE, hold_cnt=0, last=11.
  - last=11 gives requester 0 first priority after reset.
- Invariants, every cycle:
  - gnt is 0000 or exactly one-hot.
  - When gnt_valid=1, gnt == decode(gnt_id).
  - gnt_valid == |gnt.
- Priority search: pick the first set req bit scanning (last+1), (last+2), (last+3), last, all mod 4.
- Timing: all outputs update only on the clk edge, so grant latency is 1 cycle from req sampled.
- State IDLE:
  - If en=1 and req!=0: winner W per search, gnt=decode(W), gnt_id=W, last=W, hold_cnt=0, go GRANT.
  - Otherwise stay IDLE, outputs 0.
- State GRANT, owner O=gnt_id, evaluated each edge in this priority:
  1. en=0: gnt=0, gnt_valid=0, go IDLE. last and gnt_id unchanged.
  2. req[O]=0 (release):
     - Others requesting: re-arbitrate with last=O, new grant on the same edge, no idle bubble.
     - None requesting: gnt=0, go IDLE.
  3. req[O]=1, hold_cnt==MAX_HOLD-1, and another req bit set: forced rotation to the next requester after O, hold_cnt=0.
  4. req[O]=1, hold_cnt==MAX_HOLD-1, no other req: O keeps the grant, hold_cnt=0.
  5. Else hold_cnt += 1, grant unchanged.
- MAX_HOLD=1: the grant rotates every cycle while two or more requesters are active.
- Simultaneous release of O and new requests: treated as release; search starts after O.
- Requests that rise and fall between edges are never seen; arbitration is sample-based only.
- Async reset mid-grant: outputs go to 0 immediately, independent of clk. The first post-reset grant goes to the lowest-index active requester.
- gnt_id holds its last value while gnt_valid=0; consumers qualify it with gnt_valid.

Test Plan:
1. rst=1 then release, en=1, req=0000 -> gnt=0000, gnt_valid=0, gnt_id=00.
2. req=1111 held, MAX_HOLD=8 -> gnt 0001 for 8 cycles, then 0010, 0100, 1000, 0001; each owner holds exactly 8 cycles; first grant 1 cycle after req.
3. req=0100 only, held 20 cycles -> gnt=0100 continuously, no drop at the hold limit; then req=0000 -> gnt=0000 next cycle.
4. Owner 1 granted, req=0101 with req[1] dropping on the same edge req[2] rises -> next cycle gnt=0100, gnt_id=10, no idle cycle.
5. Requester 3 granted with req=1001, en pulled low for 1 cycle -> gnt=0000 next cycle. When en returns high, gnt=0001 (search starts after last=3).
6. rst asserted asynchronously mid-grant between edges -> gnt=0000 immediately. After release with req=1010, the first grant is 0010.

Source files
------------

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with a bounded hold time per ownership.
// Produces a registered one-hot grant together with its encoded index so the
// downstream 2-to-4 decoder can be driven directly from gnt_id.
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // Hold counter compares against MAX_HOLD-1: an owner sees counts 0..MAX_HOLD-1,
  // i.e. exactly MAX_HOLD grant cycles before a forced rotation.
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  state_t     state;
  logic [7:0] hold_cnt;
  logic [1:0] last;

  logic [1:0] winner;
  logic       owner_req;
  logic       others_req;
  logic       hold_at_limit;

  // Round-robin search: first set bit scanning from+1, from+2, from+3, from.
  // Walking the offsets from farthest to nearest lets the nearest one win.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] from);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = from;
    for (int i = 4; i >= 1; i--) begin
      idx = from + 2'(i);
      if (r[idx]) begin
        pick = idx;
      end
    end
    return pick;
  endfunction

  // 2-to-4 decode used to build the one-hot grant from an index.
  function automatic logic [3:0] decode2(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Arbitration inputs for the current edge; while granted, last equals the
  // owner, so one search serves idle arbitration, release and forced rotation.
  always_comb begin
    winner        = rr_pick(req, last);
    owner_req     = req[gnt_id];
    others_req    = |(req & ~decode2(gnt_id));
    hold_at_limit = (hold_cnt == HOLD_LIMIT);
  end

  // Arbitration state machine with registered grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 4'b0000;
      gnt_id    <= 2'b00;
      gnt_valid <= 1'b0;
      hold_cnt  <= 8'd0;
      last      <= 2'b11;
    end else begin
      case (state)
        IDLE: begin
          if (en && (|req)) begin
            gnt       <= decode2(winner);
            gnt_id    <= winner;
            gnt_valid <= 1'b1;
            last      <= winner;
            hold_cnt  <= 8'd0;
            state     <= GRANT;
          end else begin
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
            hold_cnt  <= 8'd0;
          end
        end

        GRANT: begin
          if (!en) begin
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
            hold_cnt  <= 8'd0;
            state     <= IDLE;
          end else if (!owner_req) begin
            if (others_req) begin
              gnt       <= decode2(winner);
              gnt_id    <= winner;
              gnt_valid <= 1'b1;
              last      <= winner;
              hold_cnt  <= 8'd0;
            end else begin
              gnt       <= 4'b0000;
              gnt_valid <= 1'b0;
              hold_cnt  <= 8'd0;
              state     <= IDLE;
            end
          end else if (hold_at_limit) begin
            if (others_req) begin
              gnt       <= decode2(winner);
              gnt_id    <= winner;
              gnt_valid <= 1'b1;
              last      <= winner;
            end
            hold_cnt <= 8'd0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

        default: begin
          gnt       <= 4'b0000;
          gnt_valid <= 1'b0;
          hold_cnt  <= 8'd0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: expected grants are queued as each step is
// driven and popped for comparison once the DUT has taken the clock edge.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [3:0] g;
    logic [1:0] id;
    logic       v;
  } exp_t;

  exp_t sb[$];

  rr_arbiter_4 #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic pushExp(input string tag, input logic [3:0] g, input logic [1:0] id, input logic v);
    exp_t e;
    e.tag = tag;
    e.g   = g;
    e.id  = id;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("[TB] FAIL scoreboard empty got=%0d want=nonzero", sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      total++;
      assert (gnt === e.g) else begin
        bad++;
        $error("[TB] FAIL %s gnt got=%b want=%b", e.tag, gnt, e.g);
      end
      total++;
      assert (gnt_id === e.id) else begin
        bad++;
        $error("[TB] FAIL %s gnt_id got=%b want=%b", e.tag, gnt_id, e.id);
      end
      total++;
      assert (gnt_valid === e.v) else begin
        bad++;
        $error("[TB] FAIL %s gnt_valid got=%b want=%b", e.tag, gnt_valid, e.v);
      end
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then check.
  task automatic applyStimulus(input string tag, input logic en_i, input logic [3:0] req_i,
                               input logic [3:0] g, input logic [1:0] id, input logic v);
    en  = en_i;
    req = req_i;
    pushExp(tag, g, id, v);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    pushExp("reset_state", 4'b0000, 2'b00, 1'b0);
    checkOutput();

    // Release reset between edges; nothing requested.
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus("idle_noreq", 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0);
    applyStimulus("idle_en_low", 1'b0, 4'b1111, 4'b0000, 2'b00, 1'b0);
    applyStimulus("idle_noreq2", 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0);

    // All four requesting: each owner holds exactly 8 cycles, then rotates.
    for (int owner = 0; owner < 4; owner++) begin
      for (int k = 0; k < 8; k++) begin
        applyStimulus($sformatf("all_req_o%0d_c%0d", owner, k), 1'b1, 4'b1111,
                      4'(4'b0001 << owner), 2'(owner), 1'b1);
      end
    end
    applyStimulus("all_req_wrap", 1'b1, 4'b1111, 4'b0001, 2'b00, 1'b1);

    // Single requester keeps the grant straight through the hold limit.
    for (int k = 0; k < 20; k++) begin
      applyStimulus($sformatf("solo2_c%0d", k), 1'b1, 4'b0100, 4'b0100, 2'b10, 1'b1);
    end
    applyStimulus("solo2_release", 1'b1, 4'b0000, 4'b0000, 2'b10, 1'b0);

    // Owner 1 releases on the same edge requester 2 rises: handover without a bubble.
    applyStimulus("grant1", 1'b1, 4'b0010, 4'b0010, 2'b01, 1'b1);
    applyStimulus("handover_1_to_2", 1'b1, 4'b0101, 4'b0100, 2'b10, 1'b1);

    // Owner 3 with req=1001, enable dropped for one cycle, then resumes at 0.
    applyStimulus("grant3", 1'b1, 4'b1000, 4'b1000, 2'b11, 1'b1);
    applyStimulus("grant3_hold", 1'b1, 4'b1001, 4'b1000, 2'b11, 1'b1);
    applyStimulus("en_drop", 1'b0, 4'b1001, 4'b0000, 2'b11, 1'b0);
    applyStimulus("en_return", 1'b1, 4'b1001, 4'b0001, 2'b00, 1'b1);

    // Asynchronous reset in the middle of a grant clears outputs without a clock.
    #3;
    rst = 1'b1;
    #1;
    pushExp("async_reset", 4'b0000, 2'b00, 1'b0);
    checkOutput();
    req = 4'b1010;
    en  = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus("post_reset_grant", 1'b1, 4'b1010, 4'b0010, 2'b01, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
